// File: rtl/pcs_am_pkg.sv
// Shared constants for the 100GbE PCS alignment-marker path.
// Holds the lane count, per-lane AM patterns, AM field constants and FSM states.
package pcs_am_pkg;

    localparam int N_LANES = 20;
    localparam int NB_AM_M = 24;

    localparam logic [1:0] AM_SYNC          = 2'b01;
    localparam logic [7:0] BIP3_PLACEHOLDER = 8'h00;
    localparam logic [7:0] BIP7_PLACEHOLDER = 8'hFF;

    // {M0,M1,M2} for each PCS lane, indexed by lane id.
    localparam logic [NB_AM_M-1:0] AM_PATTERN [N_LANES] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    typedef enum logic {
        ST_INSERT = 1'b0,
        ST_DATA   = 1'b1
    } am_state_e;

endpackage

// File: rtl/am_pattern_encoder.sv
// Combinational lane id -> 64-bit alignment-marker payload.
// Ports: lane_id (in), payload (out) = {M0,M1,M2,BIP3,~M0,~M1,~M2,BIP7}.
module am_pattern_encoder
    import pcs_am_pkg::*;
#(
    parameter int NB_LANE_ID = 5
) (
    input  logic [NB_LANE_ID-1:0] lane_id,
    output logic [63:0]           payload
);

    logic [NB_AM_M-1:0] m;

    always_comb begin
        m = '0;
        if (int'(lane_id) < N_LANES) begin
            m = AM_PATTERN[lane_id];
        end
        payload = {m, BIP3_PLACEHOLDER, ~m, BIP7_PLACEHOLDER};
    end

endmodule

// File: rtl/am_inserter.sv
// TX alignment-marker inserter: every AM period stalls upstream and emits one
// AM per PCS lane in lane order, otherwise forwards accepted blocks.
// Ports: i_clock, i_reset_n (async, active-low), i_valid/i_data/o_ready
// upstream handshake, o_valid/o_data/o_am_flag/o_lane_id registered output.
module am_inserter #(
    parameter int N_LANES    = 20,
    parameter int AM_PERIOD  = 16383,
    parameter int NB_BLOCK   = 66,
    parameter int NB_LANE_ID = $clog2(N_LANES)
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [NB_BLOCK-1:0]   i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [NB_BLOCK-1:0]   o_data,
    output logic                  o_am_flag,
    output logic [NB_LANE_ID-1:0] o_lane_id
);

    import pcs_am_pkg::*;

    localparam int BLK_W = $clog2(N_LANES * AM_PERIOD);

    localparam logic [BLK_W-1:0] BLK_LAST =
        BLK_W'(N_LANES * AM_PERIOD - 1);
    localparam logic [NB_LANE_ID-1:0] LANE_LAST =
        NB_LANE_ID'(N_LANES - 1);

    am_state_e             state;
    am_state_e             state_nxt;
    logic [NB_LANE_ID-1:0] lane_cnt;
    logic [NB_LANE_ID-1:0] lane_nxt;
    logic [BLK_W-1:0]      blk_cnt;
    logic [BLK_W-1:0]      blk_nxt;

    logic                  valid_nxt;
    logic [NB_BLOCK-1:0]   data_nxt;
    logic                  am_nxt;
    logic [NB_LANE_ID-1:0] lane_id_nxt;

    logic [63:0]           am_payload;
    logic                  accept;

    am_pattern_encoder #(
        .NB_LANE_ID (NB_LANE_ID)
    ) u_enc (
        .lane_id (lane_cnt),
        .payload (am_payload)
    );

    assign o_ready = (state == ST_DATA);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_nxt   = state;
        lane_nxt    = lane_cnt;
        blk_nxt     = blk_cnt;
        valid_nxt   = 1'b0;
        data_nxt    = '0;
        am_nxt      = 1'b0;
        lane_id_nxt = '0;
        unique case (state)
            ST_INSERT: begin
                valid_nxt   = 1'b1;
                data_nxt    = {AM_SYNC, am_payload};
                am_nxt      = 1'b1;
                lane_id_nxt = lane_cnt;
                if (lane_cnt == LANE_LAST) begin
                    state_nxt = ST_DATA;
                    lane_nxt  = '0;
                    blk_nxt   = '0;
                end else begin
                    lane_nxt = lane_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    valid_nxt = 1'b1;
                    data_nxt  = i_data;
                    // Equality compare: the counter never wraps on its own.
                    if (blk_cnt == BLK_LAST) begin
                        state_nxt = ST_INSERT;
                        blk_nxt   = '0;
                    end else begin
                        blk_nxt = blk_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_INSERT;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_INSERT;
            lane_cnt  <= '0;
            blk_cnt   <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_am_flag <= 1'b0;
            o_lane_id <= '0;
        end else begin
            state     <= state_nxt;
            lane_cnt  <= lane_nxt;
            blk_cnt   <= blk_nxt;
            o_valid   <= valid_nxt;
            o_data    <= data_nxt;
            o_am_flag <= am_nxt;
            o_lane_id <= lane_id_nxt;
        end
    end

endmodule

// File: tb/tb_am_inserter.sv
// Self-checking bench for am_inserter with AM_PERIOD=4, N_LANES=20.
// Table-driven first AM group, then a per-cycle scoreboard for data traffic.
module tb_am_inserter;

    localparam int N_LANES    = 20;
    localparam int AM_PERIOD  = 4;
    localparam int NB_BLOCK   = 66;
    localparam int NB_LANE_ID = 5;
    localparam int GROUP      = N_LANES * AM_PERIOD;

    localparam logic [65:0] HOLD = 66'h2_CAFE_F00D_0000_0000;

    logic                  i_clock = 1'b0;
    logic                  i_reset_n = 1'b0;
    logic                  i_valid = 1'b0;
    logic [NB_BLOCK-1:0]   i_data = '0;
    logic                  o_ready;
    logic                  o_valid;
    logic [NB_BLOCK-1:0]   o_data;
    logic                  o_am_flag;
    logic [NB_LANE_ID-1:0] o_lane_id;

    am_inserter #(
        .N_LANES    (N_LANES),
        .AM_PERIOD  (AM_PERIOD),
        .NB_BLOCK   (NB_BLOCK),
        .NB_LANE_ID (NB_LANE_ID)
    ) dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_am_flag (o_am_flag),
        .o_lane_id (o_lane_id)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        vin;
        logic [65:0] din;
        logic [4:0]  lane;
        logic [23:0] m;
    } vec_t;

    typedef struct {
        logic        v;
        logic        am;
        logic [4:0]  lane;
        logic [65:0] d;
    } exp_t;

    vec_t        vt [N_LANES];
    exp_t        sb [$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        m_ins;
    int          m_lane;
    int          m_blk;
    logic [65:0] cur;
    int          hold_seen;
    logic        acc;

    function automatic logic [65:0] am_blk(logic [23:0] m);
        return {2'b01, m, 8'h00, ~m, 8'hFF};
    endfunction

    task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: got output with no expectation");
        end else begin
            e = sb.pop_front();
            chk("o_valid", 66'(o_valid), 66'(e.v));
            chk("o_am_flag", 66'(o_am_flag), 66'(e.am));
            chk("o_lane_id", 66'(o_lane_id), 66'(e.lane));
            chk("o_data", o_data, e.d);
        end
        if (o_valid && !o_am_flag && o_data === HOLD) hold_seen++;
    endtask

    // One clock of stimulus: predict, drive, clock, compare.
    task automatic step(input logic v, output logic accepted);
        exp_t e;
        i_valid = v;
        i_data  = cur;
        chk("o_ready", 66'(o_ready), 66'(!m_ins));
        accepted = 1'b0;
        e = '{1'b0, 1'b0, 5'd0, 66'd0};
        if (m_ins) begin
            e = '{1'b1, 1'b1, 5'(m_lane), am_blk(vt[m_lane].m)};
            if (m_lane == N_LANES - 1) begin
                m_ins  = 1'b0;
                m_lane = 0;
                m_blk  = 0;
            end else begin
                m_lane++;
            end
        end else if (v) begin
            accepted = 1'b1;
            e = '{1'b1, 1'b0, 5'd0, cur};
            if (m_blk == GROUP - 1) begin
                m_ins = 1'b1;
                m_blk = 0;
            end else begin
                m_blk++;
            end
        end
        sb.push_back(e);
        @(posedge i_clock);
        #1;
        check_out();
        if (accepted) cur++;
    endtask

    task automatic check_zero(string name);
        chk({name, "_valid"}, 66'(o_valid), 66'd0);
        chk({name, "_data"}, o_data, 66'd0);
        chk({name, "_am"}, 66'(o_am_flag), 66'd0);
        chk({name, "_lane"}, 66'(o_lane_id), 66'd0);
        chk({name, "_ready"}, 66'(o_ready), 66'd0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        #1;
        check_zero("rst_now");
        sb.delete();
        m_ins  = 1'b1;
        m_lane = 0;
        m_blk  = 0;
        repeat (2) @(posedge i_clock);
        #1;
        check_zero("rst_hold");
        i_reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pats [N_LANES];
        pats = '{
            24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
            24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
            24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
            24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
        };
        for (int i = 0; i < N_LANES; i++) begin
            vt[i].vin  = (i % 3 == 1);
            vt[i].din  = 66'h1_1111_0000_0000_0000 + 66'(i);
            vt[i].lane = 5'(i);
            vt[i].m    = pats[i];
        end
        hold_seen = 0;
        cur = 66'h0_0000_0000_0000_1000;

        // Reset state.
        repeat (2) @(posedge i_clock);
        #1;
        check_zero("reset");
        i_reset_n = 1'b1;

        // First AM group straight after release, input ignored.
        for (int i = 0; i < N_LANES; i++) begin
            i_valid = vt[i].vin;
            i_data  = vt[i].din;
            chk("grp0_ready", 66'(o_ready), 66'd0);
            @(posedge i_clock);
            #1;
            chk("grp0_valid", 66'(o_valid), 66'd1);
            chk("grp0_am", 66'(o_am_flag), 66'd1);
            chk("grp0_lane", 66'(o_lane_id), 66'(vt[i].lane));
            chk("grp0_data", o_data, am_blk(vt[i].m));
            if (i == 0)
                chk("lane0_block", o_data, {2'b01, 64'hC1682100_3E97DEFF});
            if (i == N_LANES - 1)
                chk("lane19_block", o_data, {2'b01, 64'hC0F0E500_3F0F1AFF});
        end
        m_ins  = 1'b0;
        m_lane = 0;
        m_blk  = 0;

        // Continuous traffic across a full period, an AM group and beyond.
        for (int k = 0; k < GROUP + N_LANES + 10; k++) step(1'b1, acc);

        // Alternating valid: gaps must not advance the block count.
        for (int k = 0; k < 2 * GROUP + N_LANES + 20; k++)
            step(k % 2 == 0, acc);

        // Run into the next AM group until lane 7 is the next to emit.
        for (int k = 0; k < 400 && !(m_ins && m_lane == 7); k++)
            step(1'b1, acc);
        chk("pre_reset_am", 66'(o_am_flag), 66'd1);
        chk("pre_reset_lane", 66'(o_lane_id), 66'd6);
        do_reset();

        // Held block during the restarted group appears exactly once.
        cur = HOLD;
        hold_seen = 0;
        for (int k = 0; k < N_LANES + 6; k++) step(1'b1, acc);
        chk("hold_once", 66'(hold_seen), 66'd1);

        chk("sb_drained", 66'(sb.size()), 66'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
